// File: rtl/vector_scaler_pkg.sv
// Shared definitions for the vector scaler: FP32 field layout, canonical
// special encodings and the controller state encoding.
package vector_scaler_pkg;

    localparam int FP_W     = 32;
    localparam int FP_BIAS  = 127;
    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    localparam logic [FP_W-1:0] FP_POS_INF = 32'h7F80_0000;
    localparam logic [FP_W-1:0] FP_QNAN    = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/vector_scaler_fp32_mul.sv
// Combinational FP32 multiplier for one vector element. Subnormal inputs are
// flushed to signed zero, the mantissa product is truncated toward zero, and
// any Inf/NaN operand yields the canonical quiet NaN.
module fp32_mul
    import vector_scaler_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] p,
    output logic            ovf,
    output logic            unf,
    output logic            exc
);

    localparam logic signed [9:0] BIAS_S = 10'(FP_BIAS);

    logic                    sign;
    logic [FP_EXP_W-1:0]     ea;
    logic [FP_EXP_W-1:0]     eb;
    logic [FP_MAN_W:0]       ma;
    logic [FP_MAN_W:0]       mb;
    logic [2*FP_MAN_W+1:0]   prod;
    logic                    norm;
    logic [FP_MAN_W-1:0]     mant;
    logic signed [9:0]       exp_r;
    logic                    unused_bits;

    // Product lanes: fields, 24x24 mantissa multiply, one-step normalise, specials
    always_comb begin
        sign  = a[31] ^ b[31];
        ea    = a[30:23];
        eb    = b[30:23];
        ma    = {1'b1, a[22:0]};
        mb    = {1'b1, b[22:0]};
        prod  = ma * mb;
        norm  = prod[47];
        mant  = norm ? prod[46:24] : prod[45:23];
        exp_r = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_S
                + $signed({9'd0, norm});
        p     = {sign, exp_r[7:0], mant};
        ovf   = 1'b0;
        unf   = 1'b0;
        exc   = 1'b0;
        if (ea == 8'hFF || eb == 8'hFF) begin
            p   = FP_QNAN;
            exc = 1'b1;
        end else if (ea == 8'h00 || eb == 8'h00) begin
            p = {sign, 31'd0};
        end else if (exp_r >= 10'sd255) begin
            p   = FP_POS_INF | {sign, 31'd0};
            ovf = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            p   = {sign, 31'd0};
            unf = 1'b1;
        end
    end

    // Bits below the truncation point never reach the result
    assign unused_bits = ^prod[22:0];

endmodule

// File: rtl/vector_scaler.sv
// Sequential FP32 scalar-times-vector unit: one multiplier, one element per
// cycle, start/done handshake. Element i lives at bits [32*i +: 32].
// Optional sticky overflow/underflow/exception ports are built only when
// VECTOR_SCALER_FLAGS_EN is defined; arithmetic is identical either way.
module vector_scaler
    import vector_scaler_pkg::*;
#(
    parameter int VLEN = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          scalar,
    input  logic [32*VLEN-1:0]   A,
    output logic [32*VLEN-1:0]   result,
    output logic                 busy,
    output logic                 done
`ifdef VECTOR_SCALER_FLAGS_EN
    ,
    output logic                 overflow,
    output logic                 underflow,
    output logic                 exception
`endif
);

    localparam int IDX_W = (VLEN > 1) ? $clog2(VLEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VLEN - 1);

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [31:0]         scalar_q;
    logic [32*VLEN-1:0]  a_q;
    logic [31:0]         elem;
    logic [31:0]         prod;
    logic                mul_ovf;
    logic                mul_unf;
    logic                mul_exc;

    assign elem = a_q[32*idx +: 32];

    fp32_mul u_mul (
        .a   (elem),
        .b   (scalar_q),
        .p   (prod),
        .ovf (mul_ovf),
        .unf (mul_unf),
        .exc (mul_exc)
    );

    // Controller: operand latch on accept, one element per RUN cycle, done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        scalar_q <= scalar;
                        a_q      <= A;
                        idx      <= '0;
                        busy     <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    result[32*idx +: 32] <= prod;
                    if (idx == LAST_IDX) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef VECTOR_SCALER_FLAGS_EN
    // Sticky per-job condition flags, cleared on accept and on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            exception <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            exception <= 1'b0;
        end else if (state == ST_RUN) begin
            overflow  <= overflow  | mul_ovf;
            underflow <= underflow | mul_unf;
            exception <= exception | mul_exc;
        end
    end
`else
    logic unused_flags;
    assign unused_flags = mul_ovf ^ mul_unf ^ mul_exc;
`endif

endmodule

// File: tb/tb_vector_scaler.sv
// Directed testbench for vector_scaler (VLEN=5 main instance, VLEN=1 corner
// instance). Flag checks are compiled only with VECTOR_SCALER_FLAGS_EN.
module tb_vector_scaler;

    logic         clk;
    logic         rst;
    logic         start;
    logic [31:0]  scalar;
    logic [159:0] a_vec;
    logic [159:0] result;
    logic         busy;
    logic         done;

    logic         start1;
    logic [31:0]  scalar1;
    logic [31:0]  a1;
    logic [31:0]  result1;
    logic         busy1;
    logic         done1;

`ifdef VECTOR_SCALER_FLAGS_EN
    logic overflow, underflow, exception;
    logic overflow1, underflow1, exception1;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [159:0] V1 = {32'h00000000, 32'h3F800000, 32'hBF000000, 32'h3F28F5C3, 32'h404CCCCD};
    localparam logic [159:0] R1 = {32'h00000000, 32'h40000000, 32'hBF800000, 32'h3FA8F5C3, 32'h40CCCCCD};
    localparam logic [159:0] V2 = {32'hC0000000, 32'h40000000, 32'h3F800000, 32'h80000000, 32'h40CCCCCD};
    localparam logic [159:0] R2 = {32'h3F800000, 32'hBF800000, 32'hBF000000, 32'h00000000, 32'hC04CCCCD};
    localparam logic [159:0] V3 = {32'hFF000000, 32'h3F800000, 32'h00400000, 32'h7F800001, 32'h7F000000};
    localparam logic [159:0] R3 = {32'hFF800000, 32'h40000000, 32'h00000000, 32'h7FC00000, 32'h7F800000};
    localparam logic [159:0] V4 = {32'h3F800000, 32'h00000000, 32'h7F7FFFFF, 32'h40000000, 32'h00800000};
    localparam logic [159:0] R4 = {32'h3F000000, 32'h00000000, 32'h7EFFFFFF, 32'h3F800000, 32'h00000000};
    localparam logic [159:0] V5 = {32'h4B000000, 32'hBF800000, 32'h00800000, 32'h3FFFFFFF, 32'h3FC00000};
    localparam logic [159:0] R5 = {32'h4B400000, 32'hBFC00000, 32'h00C00000, 32'h403FFFFF, 32'h40100000};

    vector_scaler #(.VLEN(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .scalar    (scalar),
        .A         (a_vec),
        .result    (result),
        .busy      (busy),
        .done      (done)
`ifdef VECTOR_SCALER_FLAGS_EN
        ,
        .overflow  (overflow),
        .underflow (underflow),
        .exception (exception)
`endif
    );

    vector_scaler #(.VLEN(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .scalar    (scalar1),
        .A         (a1),
        .result    (result1),
        .busy      (busy1),
        .done      (done1)
`ifdef VECTOR_SCALER_FLAGS_EN
        ,
        .overflow  (overflow1),
        .underflow (underflow1),
        .exception (exception1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Full job: accept, five RUN cycles with busy high, done cycle, back to idle
    task automatic run_job(input string tag, input logic [31:0] s, input logic [159:0] v,
                           input logic [159:0] exp_r);
        start  = 1'b1;
        scalar = s;
        a_vec  = v;
        tick();
        start  = 1'b0;
        scalar = 32'hFFFF_FFFF;
        a_vec  = '1;
        for (int k = 0; k < 5; k++) begin
            check({tag, "_busy_run"}, {159'd0, busy}, 160'd1);
            check({tag, "_done_run"}, {159'd0, done}, 160'd0);
            tick();
        end
        check({tag, "_done"}, {159'd0, done}, 160'd1);
        check({tag, "_busy_done"}, {159'd0, busy}, 160'd0);
        check({tag, "_result"}, result, exp_r);
        tick();
        check({tag, "_done_clr"}, {159'd0, done}, 160'd0);
        check({tag, "_result_hold"}, result, exp_r);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; scalar = '0; a_vec = '0;
        start1 = 1'b0; scalar1 = '0; a1 = '0;
        tick();
        tick();
        check("rst_busy", {159'd0, busy}, 160'd0);
        check("rst_done", {159'd0, done}, 160'd0);
        check("rst_result", result, 160'd0);
`ifdef VECTOR_SCALER_FLAGS_EN
        check("rst_flags", {157'd0, overflow, underflow, exception}, 160'd0);
`endif

        // rst and start on the same edge: reset wins
        start = 1'b1; scalar = 32'h40000000; a_vec = V1;
        tick();
        check("rst_start_busy", {159'd0, busy}, 160'd0);
        rst = 1'b0; start = 1'b0;
        tick();
        check("rst_start_idle", {159'd0, busy}, 160'd0);

        // Job 1 with partial-write check and a second start held from T0+2 to T0+7
        start = 1'b1; scalar = 32'h40000000; a_vec = V1;
        tick();                                   // edge T0
        start = 1'b0; a_vec = '1; scalar = '0;
        check("j1_busy0", {159'd0, busy}, 160'd1);
        check("j1_none_written", result, 160'd0);
        tick();                                   // edge T0+1
        check("j1_slice0", result, {128'd0, 32'h40CCCCCD});
        start = 1'b1; scalar = 32'hBF000000; a_vec = V2;
        tick(); tick(); tick();                   // edges T0+2..T0+4
        check("j1_busy4", {159'd0, busy}, 160'd1);
        check("j1_nodone4", {159'd0, done}, 160'd0);
        tick();                                   // edge T0+5
        check("j1_done", {159'd0, done}, 160'd1);
        check("j1_busy_done", {159'd0, busy}, 160'd0);
        check("j1_result", result, R1);
        tick();                                   // edge T0+6, start ignored in DONE
        check("j1_idle_busy", {159'd0, busy}, 160'd0);
        check("j1_idle_done", {159'd0, done}, 160'd0);
        tick();                                   // edge T0+7, second job accepted
        check("j2_accept_busy", {159'd0, busy}, 160'd1);
        start = 1'b0; a_vec = '0; scalar = '0;
        tick(); tick(); tick(); tick();
        check("j2_busy_last", {159'd0, busy}, 160'd1);
        tick();
        check("j2_done", {159'd0, done}, 160'd1);
        check("j2_result", result, R2);
        tick();
        check("j2_done_clr", {159'd0, done}, 160'd0);

        run_job("j3", 32'h40000000, V3, R3);
`ifdef VECTOR_SCALER_FLAGS_EN
        check("j3_flags", {157'd0, overflow, underflow, exception}, {157'd0, 3'b101});
`endif

        run_job("j4", 32'h3F000000, V4, R4);
`ifdef VECTOR_SCALER_FLAGS_EN
        check("j4_flags", {157'd0, overflow, underflow, exception}, {157'd0, 3'b010});
`endif

        // Reset in the middle of RUN aborts the job
        start = 1'b1; scalar = 32'h40000000; a_vec = V1;
        tick();                                   // edge T0
        start = 1'b0;
        tick(); tick();                           // edges T0+1, T0+2
        rst = 1'b1;
        tick();                                   // edge T0+3
        check("abort_busy", {159'd0, busy}, 160'd0);
        check("abort_done", {159'd0, done}, 160'd0);
        check("abort_result", result, 160'd0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check("abort_no_done", {159'd0, done}, 160'd0);
            tick();
        end

        run_job("j5", 32'h3FC00000, V5, R5);
`ifdef VECTOR_SCALER_FLAGS_EN
        check("j5_flags", {157'd0, overflow, underflow, exception}, 160'd0);
`endif

        // VLEN=1 instance: single RUN cycle, done two edges after start
        start1 = 1'b1; scalar1 = 32'h3F800000; a1 = 32'h4034B4B5;
        tick();
        start1 = 1'b0; a1 = '0;
        check("v1_busy", {159'd0, busy1}, 160'd1);
        check("v1_nodone", {159'd0, done1}, 160'd0);
        tick();
        check("v1_done", {159'd0, done1}, 160'd1);
        check("v1_busy_done", {159'd0, busy1}, 160'd0);
        check("v1_result", {128'd0, result1}, {128'd0, 32'h4034B4B5});
        tick();
        check("v1_done_clr", {159'd0, done1}, 160'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
